// File: rtl/ls299_sr_if.sv
// ls299_sr_if: bus bundle for the 8-bit universal shift/storage register.
//   master: drives mode (S0/S1), enables (G1_n/G2_n), serial inputs (SR/SL)
//           and parallel data (IO_IN); observes IO_OUT, IO_OE, QA, QH.
//   slave : the register side of the same signals.
interface ls299_sr_if;
    logic       S0;
    logic       S1;
    logic       G1_n;
    logic       G2_n;
    logic       SR;
    logic       SL;
    logic [7:0] IO_IN;
    logic [7:0] IO_OUT;
    logic       IO_OE;
    logic       QA;
    logic       QH;

    modport master (
        output S0, S1, G1_n, G2_n, SR, SL, IO_IN,
        input  IO_OUT, IO_OE, QA, QH
    );

    modport slave (
        input  S0, S1, G1_n, G2_n, SR, SL, IO_IN,
        output IO_OUT, IO_OE, QA, QH
    );
endinterface

// File: rtl/ls299_sr.sv
// ls299_sr: 8-bit universal shift/storage register (hold, shift right, shift left, load).
//   CLK   : rising-edge clock for all state changes
//   CLR_n : asynchronous active-low clear of the register
//   bus   : slave side of ls299_sr_if
//           S1S0 = 00 hold, 01 shift right (SR into A), 10 shift left (SL into H), 11 load IO_IN
//           IO_OUT = register, IO_OE = bus-drive enable, QA/QH = serial taps
module ls299_sr (
    input  logic        CLK,
    input  logic        CLR_n,
    ls299_sr_if.slave   bus
);
    logic [7:0] q_q;
    logic [7:0] q_d;
    logic [1:0] mode;

    assign mode = {bus.S1, bus.S0};

    // Bit A is q[0]; shifting right moves data from A toward H.
    always_comb begin
        q_d = (mode == 2'b11) ? bus.IO_IN :
              (mode == 2'b01) ? {q_q[6:0], bus.SR} :
              (mode == 2'b10) ? {bus.SL, q_q[7:1]} : q_q;
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) q_q <= 8'h00;
        else        q_q <= q_d;
    end

    assign bus.IO_OUT = q_q;
    assign bus.QA     = q_q[0];
    assign bus.QH     = q_q[7];
    // Bus is released during load so the external driver can present IO_IN.
    assign bus.IO_OE  = ~bus.G1_n & ~bus.G2_n & ~(bus.S0 & bus.S1);
endmodule

// File: tb/tb_ls299_sr.sv
// tb_ls299_sr: directed, table-driven self-checking bench for ls299_sr, including a 16-bit cascade.
module tb_ls299_sr;
    logic CLK;
    logic CLR_n;
    int   checks;
    int   errors;

    ls299_sr_if b ();
    ls299_sr_if bl ();
    ls299_sr_if bh ();

    ls299_sr dut  (.CLK(CLK), .CLR_n(CLR_n), .bus(b));
    ls299_sr u_lo (.CLK(CLK), .CLR_n(CLR_n), .bus(bl));
    ls299_sr u_hi (.CLK(CLK), .CLR_n(CLR_n), .bus(bh));

    assign bh.SR = bl.QH;
    assign bl.SL = bh.QA;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] s1s0;
        logic       sr;
        logic       sl;
        logic       g1_n;
        logic       g2_n;
        logic [7:0] io_in;
        logic [7:0] exp_q;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic sr, input logic sl,
                         input logic g1, input logic g2, input logic [7:0] d);
        {b.S1, b.S0} = m;
        b.SR = sr;
        b.SL = sl;
        b.G1_n = g1;
        b.G2_n = g2;
        b.IO_IN = d;
    endtask

    task automatic chk_all(input string name, input logic [7:0] q, input logic oe);
        chk({name, " q"}, {8'h00, b.IO_OUT}, {8'h00, q});
        chk({name, " qa"}, {15'h0, b.QA}, {15'h0, q[0]});
        chk({name, " qh"}, {15'h0, b.QH}, {15'h0, q[7]});
        chk({name, " oe"}, {15'h0, b.IO_OE}, {15'h0, oe});
    endtask

    initial begin
        logic [15:0] m;
        checks = 0;
        errors = 0;
        //         s1s0   sr    sl    g1    g2    io_in  exp_q  oe
        vecs[0]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1};
        vecs[2]  = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0};
        vecs[3]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0};
        vecs[4]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h02, 1'b1};
        vecs[5]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h04, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h08, 1'b1};
        vecs[7]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 1'b0};
        vecs[8]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1};
        vecs[9]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC0, 1'b1};
        vecs[10] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h81, 1'b1};
        vecs[11] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0};

        CLR_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        {bl.S1, bl.S0} = 2'b00; bl.SR = 1'b0; bl.G1_n = 1'b0; bl.G2_n = 1'b0; bl.IO_IN = 8'h00;
        {bh.S1, bh.S0} = 2'b00; bh.SL = 1'b0; bh.G1_n = 1'b0; bh.G2_n = 1'b0; bh.IO_IN = 8'h00;
        #2;
        chk_all("reset", 8'h00, 1'b1);
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        tick();
        tick();
        chk_all("reset edges ignored", 8'h00, 1'b0);
        CLR_n = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].s1s0, vecs[i].sr, vecs[i].sl, vecs[i].g1_n, vecs[i].g2_n, vecs[i].io_in);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_oe);
        end

        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #2 CLR_n = 1'b0;
        #1;
        chk_all("async clear", 8'h00, 1'b1);
        drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
        tick();
        tick();
        chk_all("clear holds", 8'h00, 1'b0);
        #2 CLR_n = 1'b1;
        tick();
        chk_all("load after clear", 8'h5A, 1'b0);

        for (int i = 0; i < 8; i++) begin
            drive(i[2] ? 2'b11 : 2'b00, 1'b0, 1'b0, i[1], i[0], 8'h00);
            #1;
            chk($sformatf("oe g1=%0d g2=%0d m11=%0d", i[1], i[0], i[2]),
                {15'h0, b.IO_OE}, {15'h0, (i[2:0] == 3'b000)});
        end

        drive(2'b00, 1'bx, 1'bx, 1'bx, 1'bx, 8'hxx);
        tick();
        tick();
        chk("hold with x", {8'h00, b.IO_OUT}, 16'h005A);

        drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33);
        #2;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("mid-cycle change ignored", {8'h00, b.IO_OUT}, 16'h005A);

        {bl.S1, bl.S0} = 2'b11; {bh.S1, bh.S0} = 2'b11;
        bl.IO_IN = 8'h01; bh.IO_IN = 8'h80;
        tick();
        m = 16'h8001;
        chk("cascade load", {bh.IO_OUT, bl.IO_OUT}, m);
        chk("cascade qh edge0", {15'h0, bh.QH}, 16'h0001);
        {bl.S1, bl.S0} = 2'b01; {bh.S1, bh.S0} = 2'b01;
        bl.SR = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            m = {m[14:0], 1'b0};
            chk($sformatf("cascade edge%0d", i), {bh.IO_OUT, bl.IO_OUT}, m);
            chk($sformatf("cascade qh edge%0d", i), {15'h0, bh.QH}, {15'h0, m[15]});
        end
        chk("cascade final", {bh.IO_OUT, bl.IO_OUT}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ls299_sr.md
LS299_SR -- requirements
Module: ls299_sr

Interface
REQ-001 CLK  input  1  shift/load clock; all state changes on rising edge only (except clear).
REQ-002 CLR_n  input  1  asynchronous, active-low clear of all eight register bits.
REQ-003 S0  input  1  mode select bit 0.
REQ-004 S1  input  1  mode select bit 1.
REQ-005 G1_n  input  1  output enable 1 for the I/O bus, active-low.
REQ-006 G2_n  input  1  output enable 2 for the I/O bus, active-low.
REQ-007 SR  input  1  serial data into bit A during shift-right.
REQ-008 SL  input  1  serial data into bit H during shift-left.
REQ-009 IO_IN  input  8  parallel load data; bit0 = A, bit7 = H.
REQ-010 IO_OUT  output  8  register contents driven to the I/O bus; bit0 = A, bit7 = H.
REQ-011 IO_OE  output  1  high when IO_OUT is driven; replaces the tri-state pins.
REQ-012 QA  output  1  serial output, register bit A; always valid regardless of enables.
REQ-013 QH  output  1  serial output, register bit H; always valid regardless of enables.

Function
REQ-014 One clock domain (CLK); reset is asynchronous and active-low (CLR_n).
REQ-015 State is an 8-bit register Q[7:0] (A = Q[0], H = Q[7]); no other storage.
REQ-016 Mode decode on rising CLK with CLR_n high: S1S0 = 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-017 Hold: Q unchanged.
REQ-018 Shift right: Q[0] <= SR, Q[i] <= Q[i-1] for i = 1..7; old Q[7] discarded.
REQ-019 Shift left: Q[7] <= SL, Q[i] <= Q[i+1] for i = 0..6; old Q[0] discarded.
REQ-020 Parallel load: Q <= IO_IN.
REQ-021 Latency: Q, QA, QH and IO_OUT reflect the new value in the same cycle as the capturing edge; no pipeline stage.
REQ-022 IO_OUT = Q at all times (combinational from the register).
REQ-023 IO_OE = ~G1_n & ~G2_n & ~(S0 & S1); combinational, with no clock dependency.
REQ-024 During parallel-load mode (S0 = S1 = 1), IO_OE is 0 regardless of G1_n/G2_n, so the bus is free for loading.
REQ-025 G1_n/G2_n have no effect on Q, QA or QH.
REQ-026 QA = Q[0], QH = Q[7], combinational.
REQ-027 Mode inputs, SR, SL and IO_IN are sampled only at the rising CLK edge; changes between edges have no effect on Q.
REQ-028 Cascading: QH of one instance wired to SR of the next, and QA of the next wired to SL of the previous, forms a 16-bit shifter with no extra logic.
REQ-029 X/Z on any input other than CLR_n does not corrupt Q while mode = hold.

Reset
REQ-030 CLR_n low forces Q = 8'h00 immediately, independent of CLK.
REQ-031 While CLR_n is low, Q stays at 8'h00 and rising CLK edges are ignored in all modes.
REQ-032 During clear: QA = QH = 0, IO_OUT = 8'h00, and IO_OE still follows REQ-023.
REQ-033 Clear asserted mid-operation aborts the shift or load; the first rising CLK edge after CLR_n goes high performs the selected mode on Q = 8'h00.
REQ-034 No reset synchroniser inside the block; release timing is the integrator's responsibility.

Verification
REQ-035 Load/read-back: S1S0 = 11, IO_IN = 8'hA5, one edge -> Q = 8'hA5, QA = 1, QH = 1, IO_OE = 0; then S1S0 = 00, G1_n = G2_n = 0 -> IO_OE = 1, IO_OUT = 8'hA5.
REQ-036 Shift right: Q = 8'h81, S1S0 = 01, SR = 0, three edges -> Q = 8'h08, QH = 0.
REQ-037 Shift left: Q = 8'h01, S1S0 = 10, SL = 1, two edges -> Q = 8'hC0, QA = 0, QH = 1.
REQ-038 Async clear: Q = 8'hFF, CLR_n pulsed low between edges -> Q = 8'h00 before the next edge; edges during the low pulse leave Q = 8'h00.
REQ-039 Enable matrix: all 8 combinations of G1_n, G2_n and mode-11-vs-00 -> IO_OE = 1 only for G1_n = G2_n = 0 with mode not 11.
REQ-040 Cascade: two instances chained per REQ-028, 16'h8001 loaded, 16 shift-right edges with SR = 0 -> all bits 0, with QH of the upper instance = 1 exactly after edge 0.
